// File: rtl/serial_compare_arbiter_if.sv
// Request/operand/result bundle between two requesters and the serial comparator.
// Operands are sampled only at grant; results are registered in the comparator.
interface serial_compare_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             busy;
    logic [1:0]       done;
    logic             gt;
    logic             eq;

    // Requester side drives requests and operands.
    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  busy, done, gt, eq
    );

    // Comparator side.
    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output busy, done, gt, eq
    );
endinterface

// File: rtl/serial_compare_arbiter.sv
// Round-robin share of one 2-bit comparator between two requesters, MSB-first with early exit.
// done arrives 2..NS+1 cycles after the grant cycle; requests raised while busy wait in IDLE.
module serial_compare_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    serial_compare_arbiter_if.slave bus
);
    localparam int NS = WIDTH / 2;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gnt_q, gnt_d;
    logic             prio_q, prio_d;
    logic             busy_q, busy_d;
    logic [1:0]       done_q, done_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;

    logic [1:0] slice_a;
    logic [1:0] slice_b;
    logic       g2;
    logic       l2;
    logic       sel;

    function automatic logic gt2(input logic [1:0] x, input logic [1:0] y);
        return (x[1] & ~y[1]) | ((x[1] ~^ y[1]) & x[0] & ~y[0]);
    endfunction

    assign slice_a = sa_q[WIDTH-1 -: 2];
    assign slice_b = sb_q[WIDTH-1 -: 2];
    assign g2      = gt2(slice_a, slice_b);
    assign l2      = gt2(slice_b, slice_a);
    // Requester 1 wins when it is alone or when both ask and the pointer favours it.
    assign sel     = bus.req1 & (~bus.req0 | prio_q);

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        busy_d  = busy_q;
        done_d  = 2'b00;
        gt_d    = gt_q;
        eq_d    = eq_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    sa_d    = sel ? bus.a1 : bus.a0;
                    sb_d    = sel ? bus.b1 : bus.b0;
                    cnt_d   = '0;
                    gnt_d   = sel;
                    prio_d  = ~sel;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (g2 | l2 | (cnt_q == LAST)) begin
                    gt_d    = g2;
                    eq_d    = ~g2 & ~l2;
                    done_d  = gnt_q ? 2'b10 : 2'b01;
                    state_d = S_DONE;
                end else begin
                    sa_d  = sa_q << 2;
                    sb_d  = sb_q << 2;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 2'b00;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
endmodule

// File: tb/tb_serial_compare_arbiter.sv
// Directed vector bench for serial_compare_arbiter at WIDTH=8.
module tb_serial_compare_arbiter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    serial_compare_arbiter_if #(.WIDTH(W)) bus();
    serial_compare_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic         r0;
        logic         r1;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [1:0]   edone;
        logic         egt;
        logic         eeq;
        int           ecyc;
    } vec_t;

    vec_t vecs[8];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Counts cycles after the cycle in which the request was presented.
    task automatic run_wait(output int cyc, output logic [1:0] d, output logic g,
                            output logic e, output int busy_low);
        cyc = -1; d = 2'b00; g = 1'b0; e = 1'b0; busy_low = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!bus.busy) busy_low++;
            if (bus.done != 2'b00) begin
                cyc = k; d = bus.done; g = bus.gt; e = bus.eq;
                break;
            end
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int cyc, bl;
        logic [1:0] d;
        logic g, e;
        bus.req0 = v.r0; bus.a0 = v.a0; bus.b0 = v.b0;
        bus.req1 = v.r1; bus.a1 = v.a1; bus.b1 = v.b1;
        run_wait(cyc, d, g, e, bl);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk({tag, "_cycle"}, cyc, v.ecyc);
        chk({tag, "_done"}, int'(d), int'(v.edone));
        chk({tag, "_gt"}, int'(g), int'(v.egt));
        chk({tag, "_eq"}, int'(e), int'(v.eeq));
        chk({tag, "_busy_low"}, bl, 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle_done"}, int'(bus.done), 0);
        chk({tag, "_idle_busy"}, int'(bus.busy), 0);
        chk({tag, "_hold_gt"}, int'(bus.gt), int'(v.egt));
        chk({tag, "_hold_eq"}, int'(bus.eq), int'(v.eeq));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bl, cnt;
        logic [1:0] d;
        logic g, e;

        //           r0    r1    a0     b0     a1     b1     done   gt    eq  cyc
        vecs[0] = '{1'b1, 1'b0, 8'hB4, 8'h74, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 2};
        vecs[1] = '{1'b1, 1'b0, 8'h5A, 8'h5A, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 5};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h12, 8'h13, 2'b10, 1'b0, 1'b0, 5};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 2};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'hFE, 2'b10, 1'b1, 1'b0, 5};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h40, 2'b10, 1'b1, 1'b0, 2};
        vecs[6] = '{1'b1, 1'b0, 8'h34, 8'h38, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 4};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 5};

        reset_n = 1'b0;
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_gt", int'(bus.gt), 0);
        chk("rst_eq", int'(bus.eq), 0);

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests: pointer alternates, so requester 0 wins both rounds.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            bus.req0 = 1'b1; bus.a0 = 8'hFF; bus.b0 = 8'h00;
            bus.req1 = 1'b1; bus.a1 = 8'h00; bus.b1 = 8'hFF;
            run_wait(cyc, d, g, e, bl);
            bus.req0 = 1'b0;
            chk($sformatf("arb%0d_first_cycle", r), cyc, 2);
            chk($sformatf("arb%0d_first_done", r), int'(d), 1);
            chk($sformatf("arb%0d_first_gt", r), int'(g), 1);
            run_wait(cyc, d, g, e, bl);
            bus.req1 = 1'b0;
            chk($sformatf("arb%0d_second_cycle", r), cyc, 3);
            chk($sformatf("arb%0d_second_done", r), int'(d), 2);
            chk($sformatf("arb%0d_second_gt", r), int'(g), 0);
            chk($sformatf("arb%0d_second_eq", r), int'(e), 0);
            chk($sformatf("arb%0d_idle_gap", r), bl, 1);
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of an equal-operand run.
        apply_vec(vecs[0], "pre_rst");
        bus.req0 = 1'b1; bus.a0 = 8'h5A; bus.b0 = 8'h5A;
        repeat (3) @(posedge clk);
        #2;
        chk("midrst_busy_before", int'(bus.busy), 1);
        reset_n = 1'b0;
        bus.req0 = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_gt", int'(bus.gt), 0);
        chk("midrst_eq", int'(bus.eq), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done != 2'b00 || bus.busy) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        apply_vec(vecs[0], "post_rst");

        // Operand change and request drop in the done cycle do not disturb the result.
        bus.req0 = 1'b1; bus.a0 = 8'hB4; bus.b0 = 8'h74;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.a0 = 8'h00;
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("late_chg_done", int'(bus.done), 1);
        chk("late_chg_gt", int'(bus.gt), 1);
        chk("late_chg_eq", int'(bus.eq), 0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done != 2'b00 || bus.busy) cnt++;
        end
        chk("late_chg_no_restart", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
